btn_event_classifier: RTL
=========================

BTN_EVENT_CLASSIFIER -- requirements
Module: btn_event_classifier

Interface
REQ-001 Parameter LONG_TICKS, default 500, is the number of tick pulses a press must last to count as a long press.
REQ-002 Parameter GAP_TICKS, default 250, is the maximum number of ticks between a release and a second press for a double click.
REQ-003 Parameter CNT_W, default 10, is the tick counter width and SHALL satisfy 2^CNT_W > max(LONG_TICKS, GAP_TICKS).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 tick  input  1  one-clk-wide timebase enable, e.g. 1 kHz.
REQ-007 btn_level  input  1  debounced button level (1 = pressed), synchronous to clk.
REQ-008 short_p  output  1  one-cycle pulse: short press classified.
REQ-009 long_p  output  1  one-cycle pulse: long press threshold reached.
REQ-010 double_p  output  1  one-cycle pulse: double click classified.
REQ-011 held  output  1  level, high while in LONG state.
REQ-012 busy  output  1  level, high whenever state is not IDLE.

Function
REQ-013 The block SHALL register btn_level into prev; rise = btn_level & ~prev; fall = ~btn_level & prev.
REQ-014 FSM states SHALL be IDLE, PRESS1, GAP, PRESS2, LONG; cnt is a CNT_W-bit tick counter.
REQ-015 IDLE: rise -> PRESS1 with cnt=0; otherwise stay.
REQ-016 PRESS1: fall -> GAP with cnt=0; else on tick, cnt+1; when the tick makes cnt equal LONG_TICKS -> LONG and pulse long_p.
REQ-017 GAP: rise -> PRESS2; else on tick, cnt+1; when the tick makes cnt equal GAP_TICKS -> IDLE and pulse short_p.
REQ-018 PRESS2: fall -> IDLE and pulse double_p; ticks are ignored, so there is no long detection in PRESS2.
REQ-019 LONG: held=1; fall -> IDLE; no further pulses while held.
REQ-020 Edges SHALL take priority over tick in the same cycle; a tick coinciding with fall in PRESS1 SHALL NOT trigger long_p.
REQ-021 All outputs SHALL be registered; each pulse is high for exactly the one clk cycle after the transition edge, never two cycles.
REQ-022 At most one of short_p, long_p, double_p SHALL be high in any cycle.
REQ-023 cnt SHALL saturate and never wrap; it is cleared on every state entry.
REQ-024 btn_level and tick held high continuously SHALL produce exactly one long_p.

Reset
REQ-025 While rst_n=0 at a clk edge: state=IDLE, cnt=0, short_p=long_p=double_p=held=busy=0.
REQ-026 Reset SHALL set prev=1, so a button already pressed at reset release produces no rise until it is released and pressed again.
REQ-027 Reset mid-operation, in any state, SHALL abort classification with no pulse emitted.

Configuration
REQ-028 Macro BTN_DOUBLE_EN defined: double-click detection is as in REQ-015..REQ-019.
REQ-029 BTN_DOUBLE_EN undefined: in PRESS1, fall -> IDLE and pulse short_p in the following cycle; GAP and PRESS2 are not built; double_p is tied 0.

Verification (LONG_TICKS=4, GAP_TICKS=3, tick every 4 clk, BTN_DOUBLE_EN defined unless noted)
REQ-030 Press for 2 ticks, release, idle for 3 ticks -> exactly one short_p, on the cycle after the 3rd gap tick; busy falls with it.
REQ-031 Press held for 6 ticks -> long_p once after the 4th tick; held=1 until release; no short_p on release.
REQ-032 Press 1 tick, release 1 tick, press 1 tick, release -> double_p once, one cycle after the second fall; no short_p.
REQ-033 btn_level=1 through reset deassertion for 10 ticks, then release -> no pulses; the next press/release is classified normally.
REQ-034 Fall coinciding with the 4th tick in PRESS1 -> no long_p, enters GAP; rst_n=0 mid-GAP -> no short_p and all outputs 0.
REQ-035 BTN_DOUBLE_EN undefined: 1-tick press/release twice -> two short_p pulses, double_p stays 0.

Source files
------------

// File: rtl/btn_event_classifier.sv
`timescale 1ns/1ps
// Classifies a debounced button into short, long and double-click pulses on a tick timebase.
// Define BTN_DOUBLE_EN to build double-click detection (GAP/PRESS2); otherwise a release is reported as a short press at once.
module btn_event_classifier #(
    parameter int LONG_TICKS = 500,
    parameter int GAP_TICKS  = 250,
    parameter int CNT_W      = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_level,
    output logic short_p,
    output logic long_p,
    output logic double_p,
    output logic held,
    output logic busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRESS1 = 3'd1;
    localparam logic [2:0] S_LONG   = 3'd4;
`ifdef BTN_DOUBLE_EN
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_PRESS2 = 3'd3;
    localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_TICKS);
`endif

    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             prev_q, prev_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             held_q, held_d;
    logic             busy_q, busy_d;
`ifdef BTN_DOUBLE_EN
    logic             double_q, double_d;
`else
    logic             unused_gap_cfg;
    assign unused_gap_cfg = (GAP_TICKS > 0);
`endif

    logic             rise, fall;
    logic [CNT_W-1:0] cnt_inc;

    assign rise    = btn_level & ~prev_q;
    assign fall    = ~btn_level & prev_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Edges are handled before ticks, so a tick landing on a release can never fire long_p.
    always_comb begin
        prev_d   = btn_level;
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
`ifdef BTN_DOUBLE_EN
        double_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS1;
                    cnt_d   = '0;
                end
            end
            S_PRESS1: begin
                if (fall) begin
`ifdef BTN_DOUBLE_EN
                    state_d = S_GAP;
                    cnt_d   = '0;
`else
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
`endif
                end else if (tick) begin
                    if (cnt_inc == LONG_LIM) begin
                        state_d = S_LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
`ifdef BTN_DOUBLE_EN
            S_GAP: begin
                if (rise) begin
                    state_d = S_PRESS2;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_inc == GAP_LIM) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        short_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end
            end
`endif
            S_LONG: begin
                if (fall) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == S_LONG);
        busy_d = (state_d != S_IDLE);
    end

    // prev resets high so a button held through reset must be released before it counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q   <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef BTN_DOUBLE_EN
            double_q <= 1'b0;
`endif
        end else begin
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            held_q   <= held_d;
            busy_q   <= busy_d;
`ifdef BTN_DOUBLE_EN
            double_q <= double_d;
`endif
        end
    end

    assign short_p  = short_q;
    assign long_p   = long_q;
    assign held     = held_q;
    assign busy     = busy_q;
`ifdef BTN_DOUBLE_EN
    assign double_p = double_q;
`else
    assign double_p = 1'b0;
`endif

endmodule
